// File: rtl/conv_feature_writer.sv
`default_nettype none
// ============================================================================
// conv_feature_writer : buffers up to two convolution feature rows and writes
// them word by word into a feature-map RAM. Optional ReLU: FEATURE_RELU_EN.
// Rev 1.0
// ============================================================================
module conv_feature_writer #(
    parameter int ARRAY_SIZE   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int FEATURE_ROWS = 6,
    parameter int BASE_ADDR    = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature_in,
    input  logic [1:0]                       feature_idx,
    input  logic [2:0]                       feature_row,
    input  logic                             image_calc_fin,
    output logic                             ram_we,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_data,
    output logic                             busy,
    output logic                             overflow,
    output logic                             done
);

    localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
    localparam int COL_W = (ARRAY_SIZE > 2) ? $clog2(ARRAY_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [ROW_W-1:0]     fifo_data [2];
    logic [1:0]           fifo_idx  [2];
    logic [2:0]           fifo_row  [2];
    logic                 rd_ptr, wr_ptr;
    logic [1:0]           count;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     shreg;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                 fin_pending;
    logic                 overflow_q;
    logic                 pop, push, drop;
    logic                 fifo_empty, fifo_full, last_col;
    logic [31:0]          head_base;
    logic [DATA_WIDTH-1:0] out_word;

    assign fifo_empty = (count == 2'd0);
    assign fifo_full  = (count == 2'd2);
    assign last_col   = (col == COL_W'(ARRAY_SIZE - 1));
    assign push       = valid && (!fifo_full || pop);
    assign drop       = valid && fifo_full && !pop;

    // Row start address computed wide, then truncated to the RAM address space
    assign head_base = 32'(BASE_ADDR)
                     + (32'(fifo_idx[rd_ptr]) * 32'(FEATURE_ROWS) + 32'(fifo_row[rd_ptr]))
                     * 32'(ARRAY_SIZE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = WRITE;
                end else if (fin_pending) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                if (last_col) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            fin_pending <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (image_calc_fin)     fin_pending <= 1'b1;
            else if (state == DONE) fin_pending <= 1'b0;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= feature_in;
            fifo_idx[wr_ptr]  <= feature_idx;
            fifo_row[wr_ptr]  <= feature_row;
        end
    end

    // Shift register and address advance together; both hold after the last column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            col    <= '0;
            addr_q <= '0;
        end else if (pop) begin
            shreg  <= fifo_data[rd_ptr];
            col    <= '0;
            addr_q <= head_base[ADDR_WIDTH-1:0];
        end else if (state == WRITE && !last_col) begin
            shreg  <= shreg << DATA_WIDTH;
            col    <= col + COL_W'(1);
            addr_q <= addr_q + ADDR_WIDTH'(1);
        end
    end

    assign out_word = shreg[ROW_W-1 -: DATA_WIDTH];

`ifdef FEATURE_RELU_EN
    assign ram_data = out_word[DATA_WIDTH-1] ? '0 : out_word;
`else
    assign ram_data = out_word;
`endif

    assign ram_we   = (state == WRITE);
    assign ram_addr = addr_q;
    assign busy     = !fifo_empty || (state != IDLE);
    assign overflow = overflow_q;
    assign done     = (state == DONE);

endmodule
`default_nettype wire
